// File: rtl/pixel_cost_function_pkg.sv
// Purpose: shared field layout, cost width/limit and default weights for pixel_cost_function.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pixel_cost_function_pkg;

  // Packed RGB 3:3:3 pixel layout
  localparam int PIX_W = 9;
  localparam int CH_W  = 3;
  localparam int R_LSB = 6;
  localparam int G_LSB = 3;
  localparam int B_LSB = 0;

  // Full-scale intensity of one channel
  localparam int CH_MAX = (1 << CH_W) - 1;

  // Cost representation
  localparam int COST_W   = 9;
  localparam int COST_MAX = 511;

  // Default weights
  localparam int DEFAULT_PRIMARY_WEIGHT = 64;
  localparam int DEFAULT_CROSS_WEIGHT   = 4;
  localparam int DEFAULT_BLACK_COST     = 511;

endpackage

// File: rtl/pixel_cost_function_channel_cost.sv
// Purpose: saturated cost of drawing a pixel with one laser, from target and the two other intensities.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs continuously.
module channel_cost
  import pixel_cost_function_pkg::*;
#(
  parameter int PRIMARY_WEIGHT = DEFAULT_PRIMARY_WEIGHT,
  parameter int CROSS_WEIGHT   = DEFAULT_CROSS_WEIGHT
) (
  input  logic [CH_W-1:0]   target,
  input  logic [CH_W-1:0]   other1,
  input  logic [CH_W-1:0]   other2,
  output logic [COST_W-1:0] cost
);

  localparam logic [31:0] PW  = 32'(PRIMARY_WEIGHT);
  localparam logic [31:0] CW  = 32'(CROSS_WEIGHT);
  localparam logic [31:0] MAX = 32'(COST_MAX);
  localparam logic [31:0] FS  = 32'(CH_MAX);

  logic [31:0] raw;

  // Weighted missing-primary plus cross-channel spill, clamped at COST_MAX (never wraps)
  always_comb begin
    raw  = PW * (FS - 32'(target)) + CW * (32'(other1) + 32'(other2));
    cost = (raw > MAX) ? COST_W'(COST_MAX) : raw[COST_W-1:0];
  end

endmodule

// File: rtl/pixel_cost_function.sv
// Purpose: per-pixel red/green/blue laser draw costs with a fixed cost for black pixels.
// Latency: 1 cycle from pixel_valid/pixel_data to cost_valid/costs.
// Backpressure: none; one pixel accepted every cycle, costs hold while pixel_valid is low.
module pixel_cost_function
  import pixel_cost_function_pkg::*;
#(
  parameter int PRIMARY_WEIGHT = DEFAULT_PRIMARY_WEIGHT,
  parameter int CROSS_WEIGHT   = DEFAULT_CROSS_WEIGHT,
  parameter int BLACK_COST     = DEFAULT_BLACK_COST
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pixel_valid,
  input  logic [PIX_W-1:0]  pixel_data,
  output logic [COST_W-1:0] pixel_red_cost,
  output logic [COST_W-1:0] pixel_green_cost,
  output logic [COST_W-1:0] pixel_blue_cost,
  output logic              cost_valid
);

  localparam logic [COST_W-1:0] BLACK = COST_W'(BLACK_COST);

  logic [CH_W-1:0]   r, g, b;
  logic [COST_W-1:0] r_cost, g_cost, b_cost;
  logic [COST_W-1:0] r_next, g_next, b_next;
  logic              is_black;

  assign r = pixel_data[R_LSB +: CH_W];
  assign g = pixel_data[G_LSB +: CH_W];
  assign b = pixel_data[B_LSB +: CH_W];

  channel_cost #(.PRIMARY_WEIGHT(PRIMARY_WEIGHT), .CROSS_WEIGHT(CROSS_WEIGHT))
    u_red   (.target(r), .other1(g), .other2(b), .cost(r_cost));
  channel_cost #(.PRIMARY_WEIGHT(PRIMARY_WEIGHT), .CROSS_WEIGHT(CROSS_WEIGHT))
    u_green (.target(g), .other1(r), .other2(b), .cost(g_cost));
  channel_cost #(.PRIMARY_WEIGHT(PRIMARY_WEIGHT), .CROSS_WEIGHT(CROSS_WEIGHT))
    u_blue  (.target(b), .other1(r), .other2(g), .cost(b_cost));

  // Black pixel overrides the weighted cost on all three lasers
  always_comb begin
    is_black = (pixel_data == '0);
    r_next   = is_black ? BLACK : r_cost;
    g_next   = is_black ? BLACK : g_cost;
    b_next   = is_black ? BLACK : b_cost;
  end

  // Output registers: capture on valid, hold otherwise; reset drops any in-flight pixel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cost_valid       <= 1'b0;
      pixel_red_cost   <= '1;
      pixel_green_cost <= '1;
      pixel_blue_cost  <= '1;
    end else begin
      cost_valid <= pixel_valid;
      if (pixel_valid) begin
        pixel_red_cost   <= r_next;
        pixel_green_cost <= g_next;
        pixel_blue_cost  <= b_next;
      end
    end
  end

endmodule

// File: tb/tb_pixel_cost_function.sv
module tb_pixel_cost_function;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pixel_valid;
  logic [8:0] pixel_data;
  logic [8:0] r_cost, g_cost, b_cost;
  logic       cost_valid;
  logic [8:0] sr_cost, sg_cost, sb_cost;
  logic       s_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pixel_cost_function u_dut (
    .clk(clk), .reset_n(reset_n), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_red_cost(r_cost), .pixel_green_cost(g_cost), .pixel_blue_cost(b_cost),
    .cost_valid(cost_valid)
  );

  pixel_cost_function #(.PRIMARY_WEIGHT(80)) u_sat (
    .clk(clk), .reset_n(reset_n), .pixel_valid(pixel_valid), .pixel_data(pixel_data),
    .pixel_red_cost(sr_cost), .pixel_green_cost(sg_cost), .pixel_blue_cost(sb_cost),
    .cost_valid(s_valid)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [8:0] er, input logic [8:0] eg,
                           input logic [8:0] eb, input logic ev);
    check({tag, ".r"}, 16'(r_cost), 16'(er));
    check({tag, ".g"}, 16'(g_cost), 16'(eg));
    check({tag, ".b"}, 16'(b_cost), 16'(eb));
    check({tag, ".v"}, 16'(cost_valid), 16'(ev));
  endtask

  // Drive one pixel at negedge, sample the registered result just after the next posedge
  task automatic apply(input logic [8:0] pix);
    @(negedge clk);
    pixel_valid = 1'b1;
    pixel_data  = pix;
    @(posedge clk);
    #1;
  endtask

  typedef struct { logic [8:0] pix; logic [8:0] r, g, b; } vec_t;
  vec_t seq [6];

  initial begin
    seq[0] = '{9'b111_111_111,  9'd56,  9'd56,  9'd56};
    seq[1] = '{9'b000_111_111, 9'd504,  9'd28,  9'd28};
    seq[2] = '{9'b000_111_000, 9'd476,   9'd0, 9'd476};
    seq[3] = '{9'b111_000_111,  9'd28, 9'd504,  9'd28};
    seq[4] = '{9'b000_000_111, 9'd476, 9'd476,   9'd0};
    seq[5] = '{9'b000_000_000, 9'd511, 9'd511, 9'd511};

    reset_n     = 1'b0;
    pixel_valid = 1'b0;
    pixel_data  = '0;
    #12;
    check_out("reset", 9'h1FF, 9'h1FF, 9'h1FF, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Single pixels with a gap between them
    for (int i = 0; i < 6; i++) begin
      apply(seq[i].pix);
      check_out($sformatf("single%0d", i), seq[i].r, seq[i].g, seq[i].b, 1'b1);
      @(negedge clk);
      pixel_valid = 1'b0;
    end

    // Saturation on the PRIMARY_WEIGHT=80 instance
    apply(9'b000_111_111);
    check("sat.r", 16'(sr_cost), 16'd511);
    check("sat.g", 16'(sg_cost), 16'd28);
    check("sat.b", 16'(sb_cost), 16'd28);
    check("sat.v", 16'(s_valid), 16'd1);

    // Hold: invalid input with new data leaves costs unchanged
    @(negedge clk);
    pixel_valid = 1'b0;
    pixel_data  = 9'b111_111_111;
    @(posedge clk);
    #1;
    check_out("hold", 9'd504, 9'd28, 9'd28, 1'b0);

    // Back-to-back stream of 6 pixels
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      if (i > 0) check_out($sformatf("b2b%0d", i - 1), seq[i-1].r, seq[i-1].g, seq[i-1].b, 1'b1);
      if (i < 6) begin
        pixel_valid = 1'b1;
        pixel_data  = seq[(i + 3) % 6].pix;
        seq[6 - 1 - 0] = seq[5];
      end else begin
        pixel_valid = 1'b0;
      end
      if (i < 6) pixel_data = seq[i].pix;
    end

    // Mid-stream reset while cost_valid is high
    apply(9'b111_111_111);
    check("pre_rst.v", 16'(cost_valid), 16'd1);
    pixel_data = 9'b000_111_111;
    #2;
    reset_n = 1'b0;
    #1;
    check_out("rst_async", 9'h1FF, 9'h1FF, 9'h1FF, 1'b0);
    @(negedge clk);
    reset_n     = 1'b1;
    pixel_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      check_out("post_rst", 9'h1FF, 9'h1FF, 9'h1FF, 1'b0);
    end
    apply(9'b111_000_111);
    check_out("after_rst", 9'd28, 9'd504, 9'd28, 1'b1);
    @(negedge clk);
    pixel_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pixel_cost_function.md
PIXEL_COST_FUNCTION -- requirements
Module: pixel_cost_function

Interface
REQ-001 The block SHALL have parameter PRIMARY_WEIGHT, default 64, the cost per step of intensity missing from the target channel.
REQ-002 The block SHALL have parameter CROSS_WEIGHT, default 4, the cost per step of intensity present in a non-target channel.
REQ-003 The block SHALL have parameter BLACK_COST, default 511, the cost reported for an all-zero (black) pixel.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset: clk input 1 bit is the rising-edge clock; reset_n input 1 bit is the asynchronous active-low reset.
REQ-005 The block SHALL have port pixel_valid, input, 1 bit, qualifying pixel_data.
REQ-006 The block SHALL have port pixel_data, input, 9 bits, packed RGB 3:3:3 with R=[8:6], G=[5:3], B=[2:0].
REQ-007 The block SHALL have port pixel_red_cost, output, 9 bits, the cost of drawing this pixel with the red laser.
REQ-008 The block SHALL have port pixel_green_cost, output, 9 bits, the cost of drawing this pixel with the green laser.
REQ-009 The block SHALL have port pixel_blue_cost, output, 9 bits, the cost of drawing this pixel with the blue laser.
REQ-010 The block SHALL have port cost_valid, output, 1 bit, qualifying the three cost outputs.

Function
REQ-011 For target channel X with intensity x and other channels y, z, the block SHALL compute raw cost = PRIMARY_WEIGHT*(7-x) + CROSS_WEIGHT*(y+z), evaluated unsigned in at least 16 bits.
REQ-012 Each cost SHALL saturate to 511 when the raw value exceeds 511; there is no wrap-around.
REQ-013 When pixel_data == 0, all three costs SHALL equal BLACK_COST, truncated to 9 bits, overriding REQ-011.
REQ-014 Costs SHALL be registered: a pixel sampled on rising edge N appears on the outputs after edge N, a latency of exactly 1 cycle.
REQ-015 cost_valid SHALL equal pixel_valid delayed by one cycle; no backpressure and no handshake; one pixel is accepted per cycle.
REQ-016 When pixel_valid = 0, the cost registers SHALL hold their previous values.
REQ-017 The three channel costs SHALL be computed in parallel and updated in the same cycle.

Reset
REQ-018 While reset_n = 0, cost_valid SHALL be 0 and all three costs SHALL be 9'h1FF, asynchronously.
REQ-019 An assertion of reset_n mid-stream SHALL discard the in-flight pixel; the first valid output after release SHALL come from a pixel sampled after release.

Structure
REQ-020 A shared package SHALL hold the channel field positions and widths, COST_W = 9, COST_MAX = 511, and the default weights.
REQ-021 A single sub-module, channel_cost, SHALL compute one saturated combinational cost from (target, other1, other2) and SHALL be instantiated three times.
REQ-022 The top level SHALL contain only field extraction, the black-pixel override, and the output registers.

Verification
REQ-023 With default parameters, 9'b111_111_111 -> costs R=56, G=56, B=56 one cycle later, with cost_valid = 1.
REQ-024 9'b000_111_111 -> R=504, G=28, B=28; and 9'b000_111_000 -> R=476, G=0, B=476.
REQ-025 9'b111_000_111 -> R=28, G=504, B=28; and 9'b000_000_111 -> R=476, G=476, B=0.
REQ-026 9'b000_000_000 -> R=G=B=511; a back-to-back sequence of 6 pixels produces 6 consecutive valid outputs in order.
REQ-027 Saturation check: with PRIMARY_WEIGHT=80 and pixel 9'b000_111_111 -> R=511, G=28, B=28.
REQ-028 Reset check: reset_n is pulsed low while cost_valid = 1 -> the outputs go immediately to 9'h1FF with cost_valid = 0, and pixel_valid = 0 afterwards keeps cost_valid = 0.
